sd4_mac_sched: RTL and testbench
================================

# sd4_mac_sched

Job scheduler for the `sd4_mac` datapath: fetches 3x3 8-bit image windows (72 bits) from an image buffer and streams them into one `sd4_mac`. Weight and exponent bias stay fixed for the whole job. It tracks the MAC's fixed pipeline latency, captures each 16-bit result into a small result FIFO, and delivers results on a valid/ready port. It sits between the layer controller, which issues jobs, and the output writer.

## Interface
- `MAC_LAT`, 4: `sd4_mac` input-to-output latency in cycles; must be ≥ 1.
- `ADDR_W`, 10: image buffer address width and window-count width.
- `FDEPTH`, `MAC_LAT+4`: result FIFO depth and credit limit.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `cfg_num_win` in `ADDR_W`: number of windows in the job; 0 is legal.
- `cfg_weight` in 36: nine SD4 weights; latched on an accepted `start`.
- `cfg_exp_bias` in 5: exponent bias; latched on an accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a job.
- `img_rd_en` out 1: image buffer read strobe.
- `img_rd_addr` out `ADDR_W`: window index to read.
- `img_rd_data` in 72: read data, valid exactly 1 cycle after `img_rd_en`.
- `mac_image` out 72: registered drive to the MAC `image` input.
- `mac_weight` out 36: registered drive to the MAC `weight` input.
- `mac_exp_bias` out 5: registered drive to the MAC `exp_bias` input.
- `mac_out` in 16: MAC result.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out 16: result value.
- `res_idx` out `ADDR_W`: window index of the result.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN: on `start`, when `cfg_num_win` ≠ 0. Latch config, clear the issue counter.
  - IDLE → DONE: on `start`, when `cfg_num_win` = 0. No reads are issued.
  - RUN → DRAIN: after the read for index `num_win`-1 is issued.
  - DRAIN → DONE: when nothing is in flight, the FIFO is empty, and the last result has been handshaken.
  - DONE → IDLE: unconditionally, after one cycle. `done`=1 only in DONE.
- Issue rule: in RUN, `img_rd_en`=1 iff `inflight + fifo_count < FDEPTH`. `img_rd_addr` equals the issue counter, which increments on each issue. Back-to-back issue gives one window per cycle.
- Tag pipeline: a shift register of length `MAC_LAT+1` carries valid and index from each issue to the FIFO push.
  - `inflight` counts set tags.
  - A push and an issue in the same cycle leave `inflight` unchanged.
- The MAC has no stall and no valid. `mac_image` loads `img_rd_data` only when a tagged read returns, and holds otherwise. Untagged MAC outputs are ignored.
- The credit rule guarantees a FIFO push never meets a full FIFO. Overflow is a design error; add an assertion for it.
- `start` is ignored while not in IDLE. `cfg_*` changes mid-job have no effect.
- Async reset clears everything immediately: FSM to IDLE, counters, tags, FIFO flushed. Outputs go to 0 and no `done` is produced. A job in progress is abandoned.
- Reset value of every output is 0, including `mac_*` and `res_*`.

## Timing
- Window issued in cycle t:
  - `img_rd_data` is present in t+1.
  - `mac_image` updates at the edge ending t+1.
  - `mac_out` is sampled at the edge ending t+1+`MAC_LAT`.
  - Pushed result gives `res_valid` in t+2+`MAC_LAT` (FIFO is show-ahead).
- Minimum latency from issue to `res_valid` is `MAC_LAT`+2 cycles. Results come out strictly in index order.
- `res_data`/`res_idx` hold stable while `res_valid`=1 and `res_ready`=0.
- `done` asserts the cycle after the final handshake. `busy` drops in the same cycle `done` asserts.
- A zero-window job: `start` in cycle t gives `done` in t+1.

## Structure
- Shared package `sd4_pkg` holds:
  - widths `SD4_IMG_W`=72, `SD4_WGT_W`=36, `SD4_EXP_W`=5, `SD4_OUT_W`=16;
  - the FSM state enum;
  - default `MAC_LAT`.
- Sub-module `sd4_res_fifo`: synchronous FIFO, depth `FDEPTH`, width 16+`ADDR_W`, show-ahead, exposes `count`.
- `sd4_mac` is instantiated by the parent, not inside the scheduler.

## Test plan
- Single window: `num_win`=1, `MAC_LAT`=4, ready=1, behavioural MAC model → one result with `idx`=0 at issue+6; `done` the cycle after the handshake.
- Streaming: `num_win`=16, ready=1 → 16 consecutive `img_rd_en` cycles; results `idx` 0..15 in order, matching the model for `weight`=36'h111111111, `exp_bias`=5'b11101.
- Backpressure: `num_win`=32, ready=0 for 30 cycles then 1 → issue stalls at exactly 8 outstanding; all 32 results delivered in order; no FIFO overflow assertion fires.
- Zero job: `num_win`=0 → `done` one cycle after `start`; `img_rd_en` never asserted.
- `start` while busy: second `start` in the middle of a job → ignored; config unchanged (check `mac_weight`).
- Reset mid-job: `rst`=0 during RUN → all outputs 0 asynchronously; no `done`; a fresh job afterwards completes normally.

Source files
------------

// File: rtl/sd4_pkg.sv
// Shared widths, default MAC latency and scheduler FSM state type for the sd4_mac datapath.
package sd4_pkg;

  localparam int unsigned SD4_IMG_W   = 72;
  localparam int unsigned SD4_WGT_W   = 36;
  localparam int unsigned SD4_EXP_W   = 5;
  localparam int unsigned SD4_OUT_W   = 16;
  localparam int unsigned SD4_MAC_LAT = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sd4_state_e;

endpackage

// File: rtl/sd4_mac_sched_if.sv
// Result stream of the scheduler: valid/ready handshake carrying a MAC result and its window index.
interface sd4_mac_sched_if #(
  parameter int unsigned ADDR_W = 10
);
  import sd4_pkg::*;

  logic                 res_valid;
  logic                 res_ready;
  logic [SD4_OUT_W-1:0] res_data;
  logic [ADDR_W-1:0]    res_idx;

  modport master (output res_valid, output res_data, output res_idx, input res_ready);
  modport slave  (input res_valid, input res_data, input res_idx, output res_ready);

endinterface

// File: rtl/sd4_res_fifo.sv
// Show-ahead synchronous result FIFO with occupancy count; pushes are never expected when full.
module sd4_res_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 26,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Credit accounting upstream must make this impossible.
  overflow_a: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/sd4_mac_sched.sv
// Streams image windows into one sd4_mac, tags each issue through the MAC latency and
// buffers results in a credit-limited FIFO toward the output writer.
module sd4_mac_sched import sd4_pkg::*; #(
  parameter int unsigned MAC_LAT = SD4_MAC_LAT,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FDEPTH  = MAC_LAT + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cfg_num_win,
  input  logic [SD4_WGT_W-1:0] cfg_weight,
  input  logic [SD4_EXP_W-1:0] cfg_exp_bias,
  output logic                 busy,
  output logic                 done,
  output logic                 img_rd_en,
  output logic [ADDR_W-1:0]    img_rd_addr,
  input  logic [SD4_IMG_W-1:0] img_rd_data,
  output logic [SD4_IMG_W-1:0] mac_image,
  output logic [SD4_WGT_W-1:0] mac_weight,
  output logic [SD4_EXP_W-1:0] mac_exp_bias,
  input  logic [SD4_OUT_W-1:0] mac_out,
  sd4_mac_sched_if.master      res
);

  localparam int unsigned CNT_W = $clog2(FDEPTH + 1);
  localparam int unsigned FW    = SD4_OUT_W + ADDR_W;

  sd4_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    num_win_q, issue_cnt_q;
  logic [SD4_IMG_W-1:0] mac_image_q;
  logic [SD4_WGT_W-1:0] mac_weight_q;
  logic [SD4_EXP_W-1:0] mac_exp_bias_q;
  logic [MAC_LAT:0]     tag_vld_q;
  logic [ADDR_W-1:0]    tag_idx_q [MAC_LAT+1];
  logic [CNT_W-1:0]     inflight_q, fifo_count;
  logic [CNT_W:0]       credit_used;
  logic [FW-1:0]        fifo_rd;
  logic                 fifo_empty, issue, push, pop, accept;

  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign push        = tag_vld_q[MAC_LAT];
  assign pop         = res.res_valid && res.res_ready;
  assign accept      = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = (cfg_num_win == '0) ? StDone : StRun;
      StRun: begin
        busy  = 1'b1;
        issue = credit_used < (CNT_W + 1)'(FDEPTH);
        if (issue && issue_cnt_q == num_win_q - ADDR_W'(1)) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        // Leave as soon as the final result is being handshaken, so done follows it directly.
        if (inflight_q == '0 && !push &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      num_win_q      <= '0;
      issue_cnt_q    <= '0;
      mac_image_q    <= '0;
      mac_weight_q   <= '0;
      mac_exp_bias_q <= '0;
      tag_vld_q      <= '0;
      inflight_q     <= '0;
      for (int k = 0; k <= MAC_LAT; k++) tag_idx_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        num_win_q      <= cfg_num_win;
        mac_weight_q   <= cfg_weight;
        mac_exp_bias_q <= cfg_exp_bias;
        issue_cnt_q    <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
      end else if (state_q == StDone) begin
        issue_cnt_q <= '0;
      end
      // Read data is only meaningful the cycle after a tagged issue.
      if (tag_vld_q[0]) mac_image_q <= img_rd_data;
      tag_vld_q    <= {tag_vld_q[MAC_LAT-1:0], issue};
      tag_idx_q[0] <= issue_cnt_q;
      for (int k = 1; k <= MAC_LAT; k++) tag_idx_q[k] <= tag_idx_q[k-1];
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  sd4_res_fifo #(
    .DEPTH(FDEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({mac_out, tag_idx_q[MAC_LAT]}),
    .pop      (pop),
    .pop_data (fifo_rd),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign img_rd_en     = issue;
  assign img_rd_addr   = issue_cnt_q;
  assign mac_image     = mac_image_q;
  assign mac_weight    = mac_weight_q;
  assign mac_exp_bias  = mac_exp_bias_q;
  assign res.res_valid = !fifo_empty;
  assign res.res_data  = fifo_empty ? '0 : fifo_rd[FW-1 -: SD4_OUT_W];
  assign res.res_idx   = fifo_empty ? '0 : fifo_rd[ADDR_W-1:0];

endmodule

// File: tb/tb_sd4_mac_sched.sv
// Bench for sd4_mac_sched: image buffer and MAC behavioural models, result scoreboard.
module tb_sd4_mac_sched;
  import sd4_pkg::*;

  localparam int unsigned MAC_LAT = 4;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned FDEPTH  = MAC_LAT + 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 ready = 1'b1;
  logic [ADDR_W-1:0]    cfg_num_win = '0;
  logic [SD4_WGT_W-1:0] cfg_weight = '0;
  logic [SD4_EXP_W-1:0] cfg_exp_bias = '0;
  logic                 busy, done, img_rd_en;
  logic [ADDR_W-1:0]    img_rd_addr;
  logic [SD4_IMG_W-1:0] img_rd_data = '0;
  logic [SD4_IMG_W-1:0] mac_image;
  logic [SD4_WGT_W-1:0] mac_weight;
  logic [SD4_EXP_W-1:0] mac_exp_bias;
  logic [SD4_OUT_W-1:0] mac_out;
  logic [SD4_OUT_W-1:0] mp [MAC_LAT-1];

  sd4_mac_sched_if #(.ADDR_W(ADDR_W)) res_if ();
  assign res_if.res_ready = ready;

  sd4_mac_sched #(
    .MAC_LAT(MAC_LAT),
    .ADDR_W (ADDR_W),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_num_win (cfg_num_win),
    .cfg_weight  (cfg_weight),
    .cfg_exp_bias(cfg_exp_bias),
    .busy        (busy),
    .done        (done),
    .img_rd_en   (img_rd_en),
    .img_rd_addr (img_rd_addr),
    .img_rd_data (img_rd_data),
    .mac_image   (mac_image),
    .mac_weight  (mac_weight),
    .mac_exp_bias(mac_exp_bias),
    .mac_out     (mac_out),
    .res         (res_if.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int job_seed = 0, job_issues, job_hs, max_out;
  int first_issue_cyc, last_issue_cyc, first_valid_cyc, last_hs_cyc;
  logic [SD4_WGT_W-1:0] job_w;
  logic [SD4_EXP_W-1:0] job_eb;
  logic [SD4_OUT_W+ADDR_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] img_word(int seed, logic [ADDR_W-1:0] idx);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'((seed * 131) ^ (int'(idx) * 29) + i * 17 + i * int'(idx));
    return w;
  endfunction

  function automatic logic [15:0] mac_fn(logic [71:0] img, logic [35:0] w, logic [4:0] eb);
    logic [15:0] acc = '0;
    for (int i = 0; i < 9; i++) acc = acc + 16'(img[8*i +: 8]) * 16'(w[4*i +: 4]);
    return acc ^ {eb, 11'h0};
  endfunction

  // Image buffer: one-cycle read latency. MAC: MAC_LAT-1 stages behind the mac_image register.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (img_rd_en) img_rd_data <= img_word(job_seed, img_rd_addr);
    mp[0] <= mac_fn(mac_image, mac_weight, mac_exp_bias);
    for (int k = 1; k < MAC_LAT - 1; k++) mp[k] <= mp[k-1];
  end
  assign mac_out = mp[MAC_LAT-2];

  always @(negedge clk) begin : monitor
    logic [SD4_OUT_W+ADDR_W-1:0] e;
    if (rst) begin
      if (img_rd_en) begin
        exp_q.push_back({mac_fn(img_word(job_seed, img_rd_addr), job_w, job_eb), img_rd_addr});
        if (job_issues == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        job_issues++;
      end
      if (res_if.res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (res_if.res_valid && ready) begin
        check("res_q_nonempty", 72'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_data", res_if.res_data, e[SD4_OUT_W+ADDR_W-1 -: SD4_OUT_W]);
          check("res_idx", res_if.res_idx, e[ADDR_W-1:0]);
        end
        job_hs++;
        last_hs_cyc = cyc;
      end
      if (job_issues - job_hs > max_out) max_out = job_issues - job_hs;
    end
  end

  task automatic run_job(input int num, input logic [35:0] w, input logic [4:0] eb,
                         input int stall, input int poke_at);
    int start_cyc, done_cyc;
    logic got_done = 1'b0;
    @(posedge clk); #1;
    job_seed++; job_w = w; job_eb = eb;
    job_issues = 0; job_hs = 0; max_out = 0; first_valid_cyc = -1;
    cfg_num_win = ADDR_W'(num); cfg_weight = w; cfg_exp_bias = eb;
    start = 1'b1; ready = (stall == 0); start_cyc = cyc; done_cyc = 0;
    for (int i = 1; i <= 600 && !got_done; i++) begin
      @(posedge clk); #1;
      start = 1'b0; cfg_weight = ~w; cfg_exp_bias = ~eb; cfg_num_win = '1;
      if (i == stall) begin
        check("bp_outstanding_at_stall", job_issues, FDEPTH);
        ready = 1'b1;
      end
      if (i == poke_at) start = 1'b1;
      @(negedge clk);
      if (i == 1) check("busy_after_start", busy, num != 0);
      if (done) begin
        got_done = 1'b1; done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
    check("done_seen", got_done, 1);
    check("issue_count", job_issues, num);
    check("result_count", job_hs, num);
    check("scoreboard_empty", exp_q.size(), 0);
    check("mac_weight_held", mac_weight, w);
    check("mac_exp_bias_held", mac_exp_bias, eb);
    if (num == 0) check("zero_job_done_latency", done_cyc - start_cyc, 1);
    if (num > 0) begin
      check("issue_to_valid", first_valid_cyc - first_issue_cyc, MAC_LAT + 2);
      check("hs_to_done", done_cyc - last_hs_cyc, 1);
    end
    if (num > 0 && stall == 0) check("back_to_back_issue", last_issue_cyc - first_issue_cyc, num - 1);
    if (stall > 0) check("max_outstanding", max_out, FDEPTH);
    @(posedge clk); #1;
    cfg_weight = w;
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int n_done;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", img_rd_en, 0);
    check("rst_rd_addr", img_rd_addr, 0);
    check("rst_mac_image", mac_image, 0);
    check("rst_mac_weight", mac_weight, 0);
    check("rst_mac_exp_bias", mac_exp_bias, 0);
    check("rst_res_valid", res_if.res_valid, 0);
    check("rst_res_data", res_if.res_data, 0);
    check("rst_res_idx", res_if.res_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_job(1, 36'h123456789, 5'd3, 0, 0);
    run_job(16, 36'h111111111, 5'b11101, 0, 0);
    run_job(32, 36'h2468ace13, 5'd7, 30, 0);
    run_job(0, 36'h0f0f0f0f0, 5'd9, 0, 0);
    run_job(12, 36'h987654321, 5'd17, 0, 5);

    // Abandon a running job with an asynchronous reset.
    @(posedge clk); #1;
    job_seed++; job_w = 36'h55aa55aa5; job_eb = 5'd2;
    cfg_num_win = ADDR_W'(20); cfg_weight = job_w; cfg_exp_bias = job_eb; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_en", img_rd_en, 0);
    check("async_rst_rd_addr", img_rd_addr, 0);
    check("async_rst_mac_image", mac_image, 0);
    check("async_rst_mac_weight", mac_weight, 0);
    check("async_rst_res_valid", res_if.res_valid, 0);
    check("async_rst_res_data", res_if.res_data, 0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 0);

    run_job(6, 36'hfedcba987, 5'd30, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
